// File: rtl/alu_seq_pkg.sv
// Shared op codes, FSM states and op-classification helpers for the
// multi-byte ALU sequencer and the 8-bit ALU it drives.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_LSL = 3'b100,
    OP_LSR = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Codes above this value (3'b110, 3'b111) are rejected with err.
  localparam logic [2:0] OP_MAX_LEGAL = 3'b101;

  function automatic logic is_legal_op(input logic [2:0] op);
    return op <= OP_MAX_LEGAL;
  endfunction

  function automatic logic is_logical_op(input op_e op);
    return (op == OP_AND) || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Processor-side request/response bundle of the multi-byte ALU sequencer.
interface alu_seq_ctrl_if #(
  parameter int NBYTES = 2
);
  logic                  start;
  logic [2:0]            op;
  logic [8*NBYTES-1:0]   opA;
  logic [8*NBYTES-1:0]   opB;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [8*NBYTES-1:0]   result;
  logic                  carry_out;
  logic                  zero_out;
  logic                  pari_out;

  modport master (
    output start, op, opA, opB,
    input  busy, done, err, result, carry_out, zero_out, pari_out
  );

  modport slave (
    input  start, op, opA, opB,
    output busy, done, err, result, carry_out, zero_out, pari_out
  );
endinterface

// File: rtl/alu.sv
// Combinational 8-bit ALU slice; sc_i/sc_o chain carry, borrow or shifted bit
// between bytes. zero and pari describe the byte result.
module alu
  import alu_seq_pkg::*;
(
  input  logic [2:0] alu_cmd,
  input  logic [7:0] inA,
  input  logic [7:0] inB,
  input  logic       sc_i,
  output logic [7:0] rslt,
  output logic       sc_o,
  output logic       pari,
  output logic       zero
);

  logic [8:0] wide;

  always_comb begin
    wide = 9'd0;
    case (op_e'(alu_cmd))
      OP_ADD:  wide = {1'b0, inA} + {1'b0, inB} + {8'd0, sc_i};
      // Bit 8 of the 9-bit difference is the borrow.
      OP_SUB:  wide = {1'b0, inA} - {1'b0, inB} - {8'd0, sc_i};
      OP_AND:  wide = {1'b0, inA & inB};
      OP_XOR:  wide = {1'b0, inA ^ inB};
      OP_LSL:  wide = {inA, sc_i};
      OP_LSR:  wide = {inA[0], sc_i, inA[7:1]};
      default: wide = 9'd0;
    endcase
  end

  assign rslt = wide[7:0];
  assign sc_o = wide[8];
  assign pari = ^wide[7:0];
  assign zero = (wide[7:0] == 8'd0);

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequences one NBYTES-wide operation through the 8-bit ALU, one byte per
// cycle, chaining sc_o into the next sc_i and accumulating zero/parity.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int NBYTES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_seq_ctrl_if.slave        bus,
  output logic [2:0]           alu_cmd,
  output logic [7:0]           alu_inA,
  output logic [7:0]           alu_inB,
  output logic                 alu_sc_i,
  input  logic [7:0]           alu_rslt,
  input  logic                 alu_sc_o,
  input  logic                 alu_pari,
  input  logic                 alu_zero
);

  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NBYTES - 1);

  state_e                  state_reg, state_next;
  op_e                     op_reg;
  logic [NBYTES-1:0][7:0]  a_reg, b_reg, result_reg;
  logic [IDXW-1:0]         idx_reg;
  logic                    carry_reg, zero_acc_reg, pari_acc_reg;
  logic                    err_reg, carry_out_reg, zero_out_reg, pari_out_reg;
  logic                    accept, last_byte;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    last_byte  = 1'b0;
    alu_cmd    = 3'd0;
    alu_inA    = 8'd0;
    alu_inB    = 8'd0;
    alu_sc_i   = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = is_legal_op(bus.op) ? ST_RUN : ST_DONE;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        // LSR walks from the top byte down so bits shift toward bit 0.
        last_byte = (op_reg == OP_LSR) ? (idx_reg == '0) : (idx_reg == IDX_LAST);
        alu_cmd   = op_reg;
        alu_inA   = a_reg[idx_reg];
        alu_inB   = b_reg[idx_reg];
        alu_sc_i  = is_logical_op(op_reg) ? 1'b0 : carry_reg;
        if (last_byte) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg        <= OP_ADD;
      a_reg         <= '0;
      b_reg         <= '0;
      result_reg    <= '0;
      idx_reg       <= '0;
      carry_reg     <= 1'b0;
      zero_acc_reg  <= 1'b0;
      pari_acc_reg  <= 1'b0;
      err_reg       <= 1'b0;
      carry_out_reg <= 1'b0;
      zero_out_reg  <= 1'b0;
      pari_out_reg  <= 1'b0;
    end else if (accept) begin
      if (is_legal_op(bus.op)) begin
        op_reg       <= op_e'(bus.op);
        a_reg        <= bus.opA;
        b_reg        <= bus.opB;
        idx_reg      <= (bus.op == OP_LSR) ? IDX_LAST : '0;
        carry_reg    <= 1'b0;
        zero_acc_reg <= 1'b1;
        pari_acc_reg <= 1'b0;
        err_reg      <= 1'b0;
      end else begin
        err_reg       <= 1'b1;
        result_reg    <= '0;
        carry_out_reg <= 1'b0;
        zero_out_reg  <= 1'b1;
        pari_out_reg  <= 1'b0;
      end
    end else if (state_reg == ST_RUN) begin
      result_reg[idx_reg] <= alu_rslt;
      carry_reg           <= alu_sc_o;
      zero_acc_reg        <= zero_acc_reg & alu_zero;
      pari_acc_reg        <= pari_acc_reg ^ alu_pari;
      idx_reg             <= (op_reg == OP_LSR) ? idx_reg - 1'b1 : idx_reg + 1'b1;
      if (last_byte) begin
        carry_out_reg <= is_logical_op(op_reg) ? 1'b0 : alu_sc_o;
        zero_out_reg  <= zero_acc_reg & alu_zero;
        pari_out_reg  <= pari_acc_reg ^ alu_pari;
      end
    end
  end

  assign bus.busy      = (state_reg == ST_RUN);
  assign bus.done      = (state_reg == ST_DONE);
  assign bus.err       = err_reg;
  assign bus.result    = result_reg;
  assign bus.carry_out = carry_out_reg;
  assign bus.zero_out  = zero_out_reg;
  assign bus.pari_out  = pari_out_reg;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl (NBYTES=2) with the real alu attached.
module tb_alu_seq_ctrl;

  localparam int NB = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] alu_cmd;
  logic [7:0] alu_inA, alu_inB, alu_rslt;
  logic       alu_sc_i, alu_sc_o, alu_pari, alu_zero;

  int total = 0;
  int bad   = 0;
  int lat;
  logic saw_busy, got_done;

  alu_seq_ctrl_if #(.NBYTES(NB)) bus ();

  alu_seq_ctrl #(.NBYTES(NB)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .alu_cmd  (alu_cmd),
    .alu_inA  (alu_inA),
    .alu_inB  (alu_inB),
    .alu_sc_i (alu_sc_i),
    .alu_rslt (alu_rslt),
    .alu_sc_o (alu_sc_o),
    .alu_pari (alu_pari),
    .alu_zero (alu_zero)
  );

  alu u_alu (
    .alu_cmd (alu_cmd),
    .inA     (alu_inA),
    .inB     (alu_inB),
    .sc_i    (alu_sc_i),
    .rslt    (alu_rslt),
    .sc_o    (alu_sc_o),
    .pari    (alu_pari),
    .zero    (alu_zero)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op and wait (bounded) for done; returns cycles from the
  // sampling edge to the done cycle.
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.opA   = a;
    bus.opB   = b;
    lat = 0;
    saw_busy = 1'b0;
    got_done = 1'b0;
    while (!got_done && lat < 20) begin
      step();
      lat++;
      bus.start = 1'b0;
      if (bus.busy) saw_busy = 1'b1;
      if (bus.done) got_done = 1'b1;
    end
    check("done_seen", {31'd0, got_done}, 32'd1);
    $display("op=%0d a=%04h b=%04h -> result=%04h c=%0b z=%0b p=%0b err=%0b lat=%0d",
             op, a, b, bus.result, bus.carry_out, bus.zero_out, bus.pari_out, bus.err, lat);
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.opA   = 16'd0;
    bus.opB   = 16'd0;
    repeat (3) step();

    check("rst_busy",   {31'd0, bus.busy}, 32'd0);
    check("rst_done",   {31'd0, bus.done}, 32'd0);
    check("rst_err",    {31'd0, bus.err}, 32'd0);
    check("rst_result", {16'd0, bus.result}, 32'd0);
    check("rst_flags",  {29'd0, bus.carry_out, bus.zero_out, bus.pari_out}, 32'd0);
    check("rst_alu_cmd", {29'd0, alu_cmd}, 32'd0);
    reset = 1'b0;
    step();

    // ADD 0x00FF + 0x0001, cycle by cycle.
    bus.start = 1'b1; bus.op = 3'b000; bus.opA = 16'h00FF; bus.opB = 16'h0001;
    step();
    bus.start = 1'b0;
    check("add_t1_busy", {31'd0, bus.busy}, 32'd1);
    check("add_t1_inA",  {24'd0, alu_inA}, 32'hFF);
    check("add_t1_inB",  {24'd0, alu_inB}, 32'h01);
    check("add_t1_sci",  {31'd0, alu_sc_i}, 32'd0);
    step();
    check("add_t2_busy", {31'd0, bus.busy}, 32'd1);
    check("add_t2_done", {31'd0, bus.done}, 32'd0);
    check("add_t2_inA",  {24'd0, alu_inA}, 32'h00);
    check("add_t2_sci",  {31'd0, alu_sc_i}, 32'd1);
    step();
    check("add_t3_done", {31'd0, bus.done}, 32'd1);
    check("add_t3_busy", {31'd0, bus.busy}, 32'd0);
    check("add_result",  {16'd0, bus.result}, 32'h0100);
    check("add_carry",   {31'd0, bus.carry_out}, 32'd0);
    check("add_zero",    {31'd0, bus.zero_out}, 32'd0);
    check("add_pari",    {31'd0, bus.pari_out}, 32'd1);
    $display("op=0 a=00ff b=0001 -> result=%04h (cycle-level)", bus.result);
    step();
    check("add_done_pulse", {31'd0, bus.done}, 32'd0);
    check("add_hold",       {16'd0, bus.result}, 32'h0100);
    check("idle_alu_inA",   {24'd0, alu_inA}, 32'd0);

    run_op(3'b000, 16'hFFFF, 16'h0001);
    check("add2_lat",    lat, 32'd3);
    check("add2_result", {16'd0, bus.result}, 32'h0000);
    check("add2_carry",  {31'd0, bus.carry_out}, 32'd1);
    check("add2_zero",   {31'd0, bus.zero_out}, 32'd1);

    // Starts in the DONE cycle: back-to-back acceptance.
    run_op(3'b001, 16'h0000, 16'h0001);
    check("sub_lat",    lat, 32'd3);
    check("sub_result", {16'd0, bus.result}, 32'hFFFF);
    check("sub_borrow", {31'd0, bus.carry_out}, 32'd1);
    check("sub_zero",   {31'd0, bus.zero_out}, 32'd0);

    run_op(3'b100, 16'h4080, 16'h0000);
    check("lsl_result", {16'd0, bus.result}, 32'h8100);
    check("lsl_carry",  {31'd0, bus.carry_out}, 32'd0);

    run_op(3'b101, 16'h0101, 16'h0000);
    check("lsr_result", {16'd0, bus.result}, 32'h0080);
    check("lsr_carry",  {31'd0, bus.carry_out}, 32'd1);
    check("lsr_pari",   {31'd0, bus.pari_out}, 32'd1);

    run_op(3'b011, 16'hAA55, 16'h55AA);
    check("xor_result", {16'd0, bus.result}, 32'hFFFF);
    check("xor_pari",   {31'd0, bus.pari_out}, 32'd0);
    check("xor_zero",   {31'd0, bus.zero_out}, 32'd0);
    check("xor_carry",  {31'd0, bus.carry_out}, 32'd0);

    run_op(3'b010, 16'hAA55, 16'h55AA);
    check("and_result", {16'd0, bus.result}, 32'h0000);
    check("and_zero",   {31'd0, bus.zero_out}, 32'd1);
    check("and_carry",  {31'd0, bus.carry_out}, 32'd0);

    run_op(3'b110, 16'h1234, 16'h5678);
    check("ill_lat",    lat, 32'd1);
    check("ill_err",    {31'd0, bus.err}, 32'd1);
    check("ill_result", {16'd0, bus.result}, 32'h0000);
    check("ill_busy",   {31'd0, saw_busy}, 32'd0);
    check("ill_zero",   {31'd0, bus.zero_out}, 32'd1);

    run_op(3'b000, 16'h0001, 16'h0002);
    check("clr_err",    {31'd0, bus.err}, 32'd0);
    check("clr_result", {16'd0, bus.result}, 32'h0003);
    step();
    check("idle_done",  {31'd0, bus.done}, 32'd0);

    // start during RUN with different operands is ignored.
    bus.start = 1'b1; bus.op = 3'b000; bus.opA = 16'h0001; bus.opB = 16'h0001;
    step();
    bus.op = 3'b011; bus.opA = 16'hFFFF; bus.opB = 16'h0000;
    step();
    bus.start = 1'b0;
    step();
    check("ign_done",   {31'd0, bus.done}, 32'd1);
    check("ign_result", {16'd0, bus.result}, 32'h0002);
    $display("ignored-start run -> result=%04h", bus.result);
    step();

    // Reset in the first RUN cycle aborts the op.
    bus.start = 1'b1; bus.op = 3'b000; bus.opA = 16'h0011; bus.opB = 16'h0022;
    step();
    bus.start = 1'b0;
    reset = 1'b1;
    step();
    check("abort_busy",   {31'd0, bus.busy}, 32'd0);
    check("abort_done",   {31'd0, bus.done}, 32'd0);
    check("abort_result", {16'd0, bus.result}, 32'h0000);
    reset = 1'b0;
    step();
    step();
    check("abort_no_done", {31'd0, bus.done}, 32'd0);
    check("abort_hold",    {16'd0, bus.result}, 32'h0000);
    $display("reset-abort -> busy=%0b done=%0b result=%04h", bus.busy, bus.done, bus.result);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-byte operation sequencer for the 8-bit `alu` datapath.
- Accepts one wide operation (NBYTES bytes) by a start/done handshake. It then drives the ALU one byte per cycle, chaining `sc_o` into the next `sc_i`, and collects the per-byte results.
- Accumulates word-level zero and parity flags.
- Sits between the processor control unit and `alu`, and gives 16-bit (or wider) add/sub/shift/logic operations on the 8-bit ALU.

Parameters:
- NBYTES, 2, number of 8-bit bytes per operand (legal range 1..8).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous reset, active-high
- start  input  1  request; sampled only in IDLE or DONE
- op  input  3  operation, encoded as per alu_seq_pkg
- opA  input  8*NBYTES  operand A, latched on accepted start
- opB  input  8*NBYTES  operand B, latched on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse; result and flags are valid
- err  output  1  illegal op; valid with done
- result  output  8*NBYTES  word result; held until next accepted start
- carry_out  output  1  final `sc_o` (carry, borrow or shifted-out bit)
- zero_out  output  1  high when every result byte is zero
- pari_out  output  1  XOR of all per-byte `pari`
- alu_cmd  output  3  to ALU `alu_cmd`
- alu_inA  output  8  to ALU `inA`
- alu_inB  output  8  to ALU `inB`
- alu_sc_i  output  1  to ALU `sc_i`
- alu_rslt  input  8  from ALU `rslt`
- alu_sc_o  input  1  from ALU `sc_o`
- alu_pari  input  1  from ALU `pari`
- alu_zero  input  1  from ALU `zero`

Behaviour:
- Reset values:
  - state = IDLE.
  - busy, done, err, carry_out, pari_out = 0; zero_out = 0.
  - result = 0; byte index = 0; carry register = 0.
  - Reset asserted mid-RUN aborts the operation: no done pulse, registers cleared on that edge.
- ALU is combinational. ALU-side outputs are decoded combinationally from state, index and latched operands. In IDLE/DONE they drive cmd = 0, inA = 0, inB = 0, sc_i = 0.
- Op codes (package):
  - ADD = 000: A + B + sc_i; sc_o = carry.
  - SUB = 001: A - B - sc_i; sc_o = borrow.
  - AND = 010.
  - XOR = 011.
  - LSL = 100: sc_i into bit 0; sc_o = bit 7.
  - LSR = 101: sc_i into bit 7; sc_o = bit 0.
  - 110 and 111 are illegal.
- FSM states IDLE, RUN, DONE:
  - IDLE/DONE, start=1, legal op:
    - Latch op, opA, opB; carry register = 0; zero_acc = 1; pari_acc = 0.
    - Byte index = NBYTES-1 for LSR, otherwise 0.
    - Go to RUN.
  - IDLE/DONE, start=1, illegal op: go to DONE with err = 1, result = 0, carry_out = 0, zero_out = 1, pari_out = 0. done pulses on the next cycle.
  - IDLE/DONE, start=0: DONE returns to IDLE; IDLE holds.
  - RUN, each cycle:
    - Present byte[idx] of A and B, and sc_i = carry register. Logical ops force sc_i = 0.
    - On the edge: result byte[idx] = alu_rslt; carry register = alu_sc_o; zero_acc &= alu_zero; pari_acc ^= alu_pari.
    - idx increments, or decrements for LSR.
  - RUN, last byte (idx = NBYTES-1, or 0 for LSR): go to DONE.
    - Set done = 1 for exactly that cycle, with carry_out, zero_out and pari_out updated from the final values.
    - For AND/XOR, carry_out = 0.
- Latency: start sampled at edge t gives done high in cycle t+NBYTES+1. Back-to-back throughput is one op per NBYTES+1 cycles, because start is accepted in DONE.
- start while busy is ignored, with no queuing. opA/opB changes during RUN have no effect.
- result, carry_out, zero_out, pari_out and err hold their values until the next accepted start.

Decomposition:
- Package `alu_seq_pkg` holds:
  - op enum: ADD, SUB, AND, XOR, LSL, LSR.
  - state enum: IDLE, RUN, DONE.
  - localparam for the illegal-op check.
- No sub-module is needed. `alu` is instantiated beside this block by the parent; this block only drives its ports.
- The bench instantiates both this block and `alu`.

Test Plan (NBYTES=2, real `alu` attached):
- ADD, opA=0x00FF, opB=0x0001, start at edge t -> busy in t+1..t+2; done at t+3; result=0x0100, carry_out=0, zero_out=0.
- ADD, 0xFFFF + 0x0001 -> result=0x0000, carry_out=1, zero_out=1. Then SUB 0x0000 - 0x0001 -> result=0xFFFF, carry_out=1 (borrow).
- LSL, opA=0x4080 -> result=0x8100, carry_out=0. LSR, opA=0x0101 -> high byte processed first; result=0x0080, carry_out=1.
- XOR, 0xAA55 ^ 0x55AA -> result=0xFFFF, pari_out=0, zero_out=0, carry_out=0. AND with the same operands -> result=0x0000, zero_out=1.
- Illegal op 3'b110 -> done at t+1, err=1, result=0x0000, busy never high. Next legal start clears err.
- start pulsed during RUN with different operands -> ignored, first op's result unchanged. reset asserted in first RUN cycle -> busy=0 next cycle, no done, result=0.
